microsequencer: RTL and testbench
=================================

// Module: microsequencer
// PURPOSE
//  Next-state address generator for the microprogrammed control unit. Consumes the
//  sequencing fields of the microstore control word plus status inputs, registers
//  next_state each clock, and feeds that index back to the microstore.
//  Closes the control loop: microstore emits the control word, this block picks the address.
// PARAMETERS
//  ADDR_W       10    width of microstore state index
//  FAULT_STATE  10'd5 state entered on memory timeout or stack error
//  MOC_TIMEOUT  16    max consecutive MWAIT cycles without moc; 0 = watchdog disabled
//  STACK_DEPTH  4     return-address stack entries (only with MICRO_STACK_EN)
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       reset, synchronous, active-high
//  enc_state   in   ADDR_W  decode-entry state from instruction encoder
//  cr_addr     in   ADDR_W  control-register target address field of control word
//  ns_sel      in   3       next-state select field of control word
//  cond_inv    in   1       invert condition for CBR
//  cond_in     in   1       selected condition (flag/test result)
//  moc         in   1       memory operation complete
//  next_state  out  ADDR_W  registered state index to microstore
//  stall       out  1       comb: ns_sel==MWAIT && !moc
//  mem_fault   out  1       1-cycle pulse on MOC timeout
//  stack_err   out  1       1-cycle pulse on stack over/underflow
// BEHAVIOUR
//  Reset: next_state=0, mem_fault=0, stack_err=0, wait_cnt=0, sp=0, stack contents=0.
//  Reset wins over any ns_sel; asserting it mid-wait or mid-call discards all state.
//  All updates on the rising edge; one-cycle latency from inputs to next_state.
//  inc = next_state+1 mod 2^ADDR_W (1023 -> 0 for ADDR_W=10).
//  ns_sel codes:
//   0 ENC    next=enc_state
//   1 INC    next=inc
//   2 JMP    next=cr_addr
//   3 CBR    next=(cond_in^cond_inv) ? cr_addr : inc
//   4 MWAIT  moc ? inc : hold next_state (stall=1)
//   5 CALL   see CONFIGURATION
//   6 RET    see CONFIGURATION
//   7 RST    next=0 (restart fetch)
//  Watchdog: wait_cnt increments each MWAIT cycle with moc=0. It clears on moc=1 or any
//   other ns_sel. When wait_cnt==MOC_TIMEOUT-1 and moc=0: next=FAULT_STATE,
//   mem_fault=1 for one cycle, wait_cnt=0. moc=1 on the same cycle takes priority (inc).
//  mem_fault and stack_err are registered, high exactly one cycle per event.
// CONFIGURATION
//  MICRO_STACK_EN defined: STACK_DEPTH-entry LIFO, sp 0..STACK_DEPTH.
//   CALL: push inc, next=cr_addr. If full: no push, next=FAULT_STATE, stack_err pulse.
//   RET: pop, next=top. If empty: next=0, stack_err pulse.
//  MICRO_STACK_EN undefined: no stack hardware; CALL and RET behave as INC;
//   stack_err tied 0.
// TESTING
//  T1 reset=1 for 2 clk with ns_sel=2, cr_addr=9 -> next_state=0, all pulses 0.
//  T2 ns_sel=0, enc_state=20 -> next_state=20; then ns_sel=1 x3 -> 21,22,23;
//     next_state=1023 with INC -> 0.
//  T3 CBR cr_addr=42: cond_in=1,inv=0 -> 42; cond_in=1,inv=1 from 42 -> 43.
//  T4 MWAIT at state 3, moc low 4 clk then high -> held at 3 with stall=1 for 4 clk,
//     then 4; moc never high, MOC_TIMEOUT=16 -> FAULT_STATE after 16th clk,
//     mem_fault high one clk.
//  T5 (MICRO_STACK_EN) CALL cr_addr=200 from 10 -> 200; RET -> 11;
//     5 nested CALLs -> 5th gives FAULT_STATE + stack_err; RET on empty -> 0 + stack_err.
//  T6 (no macro) CALL from 10 -> 11, stack_err stays 0; reset mid-MWAIT -> 0, wait_cnt cleared.

Source files
------------

// File: rtl/microsequencer.sv
// Next-state address generator for the microprogrammed control unit.
// Define MICRO_STACK_EN to add the CALL/RET return-address stack.
module microsequencer #(
    parameter int unsigned        ADDR_W      = 10,
    parameter logic [ADDR_W-1:0]  FAULT_STATE = ADDR_W'(5),
    parameter int unsigned        MOC_TIMEOUT = 16,
    parameter int unsigned        STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] enc_state,
    input  logic [ADDR_W-1:0] cr_addr,
    input  logic [2:0]        ns_sel,
    input  logic              cond_inv,
    input  logic              cond_in,
    input  logic              moc,
    output logic [ADDR_W-1:0] next_state,
    output logic              stall,
    output logic              mem_fault,
    output logic              stack_err
);

    typedef enum logic [2:0] {
        SelEnc, SelInc, SelJmp, SelCbr, SelMwait, SelCall, SelRet, SelRst
    } ns_sel_e;

    localparam int unsigned WCW = (MOC_TIMEOUT > 1) ? $clog2(MOC_TIMEOUT) : 1;
    localparam logic [WCW-1:0] WaitLast = WCW'((MOC_TIMEOUT > 0) ? MOC_TIMEOUT - 1 : 0);

    ns_sel_e           sel;
    logic [ADDR_W-1:0] state_q, state_d, inc;
    logic [WCW-1:0]    wait_q, wait_d;
    logic              fault_q, fault_d;

    assign sel        = ns_sel_e'(ns_sel);
    assign inc        = state_q + ADDR_W'(1);
    assign next_state = state_q;
    assign mem_fault  = fault_q;
    assign stall      = (sel == SelMwait) && !moc;

`ifdef MICRO_STACK_EN
    localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
    logic [SPW-1:0]    sp_q, sp_d;
    logic [IDW-1:0]    push_idx, top_idx;
    logic              serr_q, serr_d;

    assign push_idx  = IDW'(sp_q);
    assign top_idx   = IDW'(sp_q - SPW'(1));
    assign stack_err = serr_q;
`else
    assign stack_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        fault_d = 1'b0;
`ifdef MICRO_STACK_EN
        stack_d = stack_q;
        sp_d    = sp_q;
        serr_d  = 1'b0;
`endif
        unique case (sel)
            SelEnc: state_d = enc_state;
            SelInc: state_d = inc;
            SelJmp: state_d = cr_addr;
            SelCbr: state_d = (cond_in ^ cond_inv) ? cr_addr : inc;
            SelMwait: begin
                // moc on the final allowed cycle still wins over the timeout
                if (moc) begin
                    state_d = inc;
                end else if (MOC_TIMEOUT != 0 && wait_q == WaitLast) begin
                    state_d = FAULT_STATE;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end
            SelCall: begin
`ifdef MICRO_STACK_EN
                if (sp_q == SPW'(STACK_DEPTH)) begin
                    state_d = FAULT_STATE;
                    serr_d  = 1'b1;
                end else begin
                    stack_d[push_idx] = inc;
                    sp_d              = sp_q + SPW'(1);
                    state_d           = cr_addr;
                end
`else
                state_d = inc;
`endif
            end
            SelRet: begin
`ifdef MICRO_STACK_EN
                if (sp_q == '0) begin
                    state_d = '0;
                    serr_d  = 1'b1;
                end else begin
                    state_d = stack_q[top_idx];
                    sp_d    = sp_q - SPW'(1);
                end
`else
                state_d = inc;
`endif
            end
            SelRst: state_d = '0;
            default: state_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
            wait_q  <= '0;
            fault_q <= 1'b0;
`ifdef MICRO_STACK_EN
            sp_q    <= '0;
            serr_q  <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
`endif
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
`ifdef MICRO_STACK_EN
            sp_q    <= sp_d;
            serr_q  <= serr_d;
            stack_q <= stack_d;
`endif
        end
    end

endmodule

// File: tb/tb_microsequencer.sv
// Bench for microsequencer: directed scenarios plus randomized traffic against a
// queue-based reference model. Honours MICRO_STACK_EN like the design.
module tb_microsequencer;

    localparam int unsigned ADDR_W  = 10;
    localparam int          FAULT   = 5;
    localparam int          TIMEOUT = 16;
    localparam int          DEPTH   = 4;
`ifdef MICRO_STACK_EN
    localparam bit StackOn = 1'b1;
`else
    localparam bit StackOn = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] enc_state, cr_addr, next_state;
    logic [2:0]        ns_sel;
    logic              cond_inv, cond_in, moc;
    logic              stall, mem_fault, stack_err;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int m_state = 0;
    int m_wait  = 0;
    bit m_fault = 0;
    bit m_serr  = 0;
    int m_stack[$];

    microsequencer #(
        .ADDR_W     (ADDR_W),
        .FAULT_STATE(ADDR_W'(FAULT)),
        .MOC_TIMEOUT(TIMEOUT),
        .STACK_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enc_state (enc_state),
        .cr_addr   (cr_addr),
        .ns_sel    (ns_sel),
        .cond_inv  (cond_inv),
        .cond_in   (cond_in),
        .moc       (moc),
        .next_state(next_state),
        .stall     (stall),
        .mem_fault (mem_fault),
        .stack_err (stack_err)
    );

    always #5 clk = ~clk;

    task automatic drive(input int sel, input int cr = 0, input int enc = 0,
                         input bit cin = 0, input bit cinv = 0, input bit m = 0);
        ns_sel    = 3'(sel);
        cr_addr   = ADDR_W'(cr);
        enc_state = ADDR_W'(enc);
        cond_in   = cin;
        cond_inv  = cinv;
        moc       = m;
    endtask

    task automatic model_step();
        int inc;
        int nxt;
        inc     = (m_state + 1) % (1 << ADDR_W);
        nxt     = m_state;
        m_fault = 0;
        m_serr  = 0;
        if (reset) begin
            m_state = 0;
            m_wait  = 0;
            m_stack.delete();
            return;
        end
        if (ns_sel != 3'd4) m_wait = 0;
        case (ns_sel)
            3'd0: nxt = int'(enc_state);
            3'd1: nxt = inc;
            3'd2: nxt = int'(cr_addr);
            3'd3: nxt = (cond_in != cond_inv) ? int'(cr_addr) : inc;
            3'd4: begin
                if (moc) begin
                    nxt = inc; m_wait = 0;
                end else if (m_wait + 1 == TIMEOUT) begin
                    nxt = FAULT; m_fault = 1; m_wait = 0;
                end else begin
                    m_wait++;
                end
            end
            3'd5: begin
                if (!StackOn) nxt = inc;
                else if (m_stack.size() == DEPTH) begin nxt = FAULT; m_serr = 1; end
                else begin m_stack.push_back(inc); nxt = int'(cr_addr); end
            end
            3'd6: begin
                if (!StackOn) nxt = inc;
                else if (m_stack.size() == 0) begin nxt = 0; m_serr = 1; end
                else nxt = m_stack.pop_back();
            end
            default: nxt = 0;
        endcase
        m_state = nxt;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(2, 9);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (next_state !== 0 || mem_fault !== 1'b0 || stack_err !== 1'b0)
                $display("FAIL reset[%0d]: state=%0d mf=%b se=%b expected 0/0/0",
                         i, next_state, mem_fault, stack_err);
            else n_pass++;
        end
        reset = 1'b0;
    endtask

    task automatic test_enc_inc();
        drive(0, 0, 20);
        tick();
        n_checks++;
        if (next_state !== 10'd20) $display("FAIL enc_load: state=%0d expected 20", next_state);
        else n_pass++;
        for (int i = 1; i <= 3; i++) begin
            drive(1);
            tick();
            n_checks++;
            if (next_state !== ADDR_W'(20 + i))
                $display("FAIL inc[%0d]: state=%0d expected %0d", i, next_state, 20 + i);
            else n_pass++;
        end
        drive(2, 1023);
        tick();
        drive(1);
        tick();
        n_checks++;
        if (next_state !== 10'd0) $display("FAIL inc_wrap: state=%0d expected 0", next_state);
        else n_pass++;
    endtask

    task automatic test_cbr();
        drive(3, 42, 0, 1, 0);
        tick();
        n_checks++;
        if (next_state !== 10'd42) $display("FAIL cbr_taken: state=%0d expected 42", next_state);
        else n_pass++;
        drive(3, 42, 0, 1, 1);
        tick();
        n_checks++;
        if (next_state !== 10'd43) $display("FAIL cbr_inv: state=%0d expected 43", next_state);
        else n_pass++;
        drive(3, 42, 0, 0, 1);
        tick();
        n_checks++;
        if (next_state !== 10'd42)
            $display("FAIL cbr_inv_taken: state=%0d expected 42", next_state);
        else n_pass++;
    endtask

    task automatic test_mwait();
        drive(2, 3);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(4, 0, 0, 0, 0, 0);
            #1;
            n_checks++;
            if (stall !== 1'b1) $display("FAIL mwait_stall[%0d]: stall=%b expected 1", i, stall);
            else n_pass++;
            tick();
            n_checks++;
            if (next_state !== 10'd3 || mem_fault !== 1'b0)
                $display("FAIL mwait_hold[%0d]: state=%0d mf=%b expected 3/0",
                         i, next_state, mem_fault);
            else n_pass++;
        end
        drive(4, 0, 0, 0, 0, 1);
        #1;
        n_checks++;
        if (stall !== 1'b0) $display("FAIL mwait_moc_stall: stall=%b expected 0", stall);
        else n_pass++;
        tick();
        n_checks++;
        if (next_state !== 10'd4) $display("FAIL mwait_done: state=%0d expected 4", next_state);
        else n_pass++;
        drive(2, 3);
        tick();
        for (int i = 1; i <= 16; i++) begin
            drive(4, 0, 0, 0, 0, 0);
            tick();
            n_checks++;
            if (i < 16 && (next_state !== 10'd3 || mem_fault !== 1'b0))
                $display("FAIL timeout_hold[%0d]: state=%0d mf=%b expected 3/0",
                         i, next_state, mem_fault);
            else if (i == 16 && (next_state !== ADDR_W'(FAULT) || mem_fault !== 1'b1))
                $display("FAIL timeout_fault: state=%0d mf=%b expected %0d/1",
                         next_state, mem_fault, FAULT);
            else n_pass++;
        end
        drive(1);
        tick();
        n_checks++;
        if (mem_fault !== 1'b0 || next_state !== ADDR_W'(FAULT + 1))
            $display("FAIL fault_pulse: state=%0d mf=%b expected %0d/0",
                     next_state, mem_fault, FAULT + 1);
        else n_pass++;
    endtask

`ifdef MICRO_STACK_EN
    task automatic test_stack();
        int exp_ret[4];
        exp_ret = '{103, 102, 101, 12};
        drive(2, 10);
        tick();
        drive(5, 200);
        tick();
        n_checks++;
        if (next_state !== 10'd200) $display("FAIL call: state=%0d expected 200", next_state);
        else n_pass++;
        drive(6);
        tick();
        n_checks++;
        if (next_state !== 10'd11) $display("FAIL ret: state=%0d expected 11", next_state);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            drive(5, 100 + i);
            tick();
            n_checks++;
            if (i < 4 && (next_state !== ADDR_W'(100 + i) || stack_err !== 1'b0))
                $display("FAIL nest_call[%0d]: state=%0d se=%b expected %0d/0",
                         i, next_state, stack_err, 100 + i);
            else if (i == 4 && (next_state !== ADDR_W'(FAULT) || stack_err !== 1'b1))
                $display("FAIL overflow: state=%0d se=%b expected %0d/1",
                         next_state, stack_err, FAULT);
            else n_pass++;
        end
        drive(1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(6);
            tick();
            n_checks++;
            if (next_state !== ADDR_W'(exp_ret[i]) || stack_err !== 1'b0)
                $display("FAIL unwind[%0d]: state=%0d se=%b expected %0d/0",
                         i, next_state, stack_err, exp_ret[i]);
            else n_pass++;
        end
        drive(6);
        tick();
        n_checks++;
        if (next_state !== 10'd0 || stack_err !== 1'b1)
            $display("FAIL underflow: state=%0d se=%b expected 0/1", next_state, stack_err);
        else n_pass++;
        drive(5, 300);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(6);
        tick();
        n_checks++;
        if (next_state !== 10'd0 || stack_err !== 1'b1)
            $display("FAIL reset_mid_call: state=%0d se=%b expected 0/1", next_state, stack_err);
        else n_pass++;
    endtask
`else
    task automatic test_no_stack();
        drive(2, 10);
        tick();
        drive(5, 200);
        tick();
        n_checks++;
        if (next_state !== 10'd11 || stack_err !== 1'b0)
            $display("FAIL call_as_inc: state=%0d se=%b expected 11/0", next_state, stack_err);
        else n_pass++;
        drive(6);
        tick();
        n_checks++;
        if (next_state !== 10'd12 || stack_err !== 1'b0)
            $display("FAIL ret_as_inc: state=%0d se=%b expected 12/0", next_state, stack_err);
        else n_pass++;
    endtask
`endif

    task automatic test_reset_mid_wait();
        bit bad;
        drive(4);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (next_state !== 10'd0) $display("FAIL reset_mid_wait: state=%0d expected 0", next_state);
        else n_pass++;
        bad = 0;
        drive(4);
        repeat (15) begin
            tick();
            if (next_state !== 10'd0 || mem_fault !== 1'b0) bad = 1;
        end
        n_checks++;
        if (bad) $display("FAIL wait_cleared: state=%0d mf=%b expected 0/0 for 15 clk",
                          next_state, mem_fault);
        else n_pass++;
        tick();
        n_checks++;
        if (next_state !== ADDR_W'(FAULT) || mem_fault !== 1'b1)
            $display("FAIL wait_refault: state=%0d mf=%b expected %0d/1",
                     next_state, mem_fault, FAULT);
        else n_pass++;
    endtask

    task automatic test_random();
        int burst = 0;
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            if (burst == 0 && $urandom_range(0, 19) == 0) burst = $urandom_range(14, 20);
            if (burst > 0) begin
                drive(4, 0, 0, 0, 0, ($urandom_range(0, 15) == 0));
                burst--;
            end else begin
                drive($urandom_range(0, 7), $urandom_range(0, 1023), $urandom_range(0, 1023),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
            end
            #1;
            n_checks++;
            if (stall !== (ns_sel == 3'd4 && !moc))
                $display("FAIL rand_stall[%0d]: stall=%b sel=%0d moc=%b", i, stall, ns_sel, moc);
            else n_pass++;
            tick();
            n_checks++;
            if (next_state !== ADDR_W'(m_state) || mem_fault !== m_fault || stack_err !== m_serr)
                $display("FAIL rand[%0d]: state=%0d mf=%b se=%b expected %0d/%b/%b",
                         i, next_state, mem_fault, stack_err, m_state, m_fault, m_serr);
            else n_pass++;
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        drive(1);
        @(negedge clk);
        test_reset();
        test_enc_inc();
        test_cbr();
        test_mwait();
`ifdef MICRO_STACK_EN
        test_stack();
`else
        test_no_stack();
`endif
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
